// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL mode sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    STABLE,
    APPLY,
    WAIT_UNLOCK,
    WAIT_LOCK,
    SETTLE,
    RUN,
    RETRY,
    ERROR
  } state_t;

  localparam int unsigned UNLOCK_GRACE = 64;

  typedef logic [7:0] mode_t;

endpackage

// File: rtl/pll_mode_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/pll_mode_sequencer.sv
// Qualifies a requested video mode, drives the PLL reconfig handshake and
// holds the video domain in reset until the new clock has settled.
module pll_mode_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mode_in,
  input  logic       pll_locked_async,
  output logic [7:0] mode_out,
  output logic       reconfig_req,
  output logic       video_reset,
  output logic [7:0] mode_active,
  output logic       busy,
  output logic       error
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  state_t        r_state;
  mode_t         r_mode_q, r_mode_prev, r_mode_out, r_mode_active;
  logic [SW-1:0] r_stable_cnt;
  logic [TW-1:0] r_settle_cnt;
  logic [20:0]   r_timeout_cnt;
  logic [RW-1:0] r_retry_cnt;
  logic          r_req, r_video_reset, r_busy, r_error;

  logic w_locked_s, w_mode_chg, w_mode_stable;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_async (pll_locked_async),
    .o_sync  (w_locked_s)
  );

  assign w_mode_chg    = (r_mode_q != r_mode_prev);
  assign w_mode_stable = (r_stable_cnt == SW'(STABLE_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode_q     <= '0;
      r_mode_prev  <= '0;
      r_stable_cnt <= '0;
    end else begin
      r_mode_q    <= mode_in;
      r_mode_prev <= r_mode_q;
      if (w_mode_chg)          r_stable_cnt <= '0;
      else if (!w_mode_stable) r_stable_cnt <= r_stable_cnt + SW'(1);
    end
  end

  // Timeout spans unlock, lock and settle of one attempt; APPLY and RUN restart it.
  always_ff @(posedge clock) begin
    if (reset || r_state == APPLY || r_state == RUN)
      r_timeout_cnt <= '0;
    else if ((r_state == WAIT_UNLOCK || r_state == WAIT_LOCK || r_state == SETTLE)
             && r_timeout_cnt != '1)
      r_timeout_cnt <= r_timeout_cnt + 21'd1;
  end

  always_ff @(posedge clock) begin
    if (reset || r_state != SETTLE)              r_settle_cnt <= '0;
    else if (r_settle_cnt != TW'(SETTLE_CYCLES)) r_settle_cnt <= r_settle_cnt + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= STABLE;
      r_mode_out    <= '0;
      r_mode_active <= '0;
      r_req         <= 1'b0;
      r_video_reset <= 1'b1;
      r_busy        <= 1'b1;
      r_error       <= 1'b0;
      r_retry_cnt   <= '0;
    end else begin
      r_req <= 1'b0;
      case (r_state)
        STABLE: if (w_mode_stable) begin
          r_state    <= APPLY;
          r_req      <= 1'b1;
          r_mode_out <= r_mode_q;
        end
        APPLY: r_state <= WAIT_UNLOCK;
        WAIT_UNLOCK: begin
          if (w_mode_chg) r_state <= STABLE;
          else if (!w_locked_s || r_timeout_cnt >= 21'(UNLOCK_GRACE)) r_state <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (w_mode_chg)      r_state <= STABLE;
          else if (w_locked_s) r_state <= SETTLE;
          else if (r_timeout_cnt >= 21'(LOCK_TIMEOUT - 1)) r_state <= RETRY;
        end
        SETTLE: begin
          if (w_mode_chg)       r_state <= STABLE;
          else if (!w_locked_s) r_state <= WAIT_LOCK;
          else if (r_settle_cnt == TW'(SETTLE_CYCLES - 1)) begin
            r_state       <= RUN;
            r_video_reset <= 1'b0;
            r_busy        <= 1'b0;
            r_mode_active <= r_mode_out;
            r_retry_cnt   <= '0;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            r_state       <= WAIT_LOCK;
            r_video_reset <= 1'b1;
            r_busy        <= 1'b1;
          end else if (r_mode_q != r_mode_active) begin
            r_state       <= STABLE;
            r_video_reset <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        RETRY: begin
          if (r_retry_cnt == RW'(MAX_RETRIES)) begin
            r_state <= ERROR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_retry_cnt <= r_retry_cnt + RW'(1);
            r_state     <= APPLY;
            r_req       <= 1'b1;
            r_mode_out  <= r_mode_q;
          end
        end
        ERROR: r_state <= ERROR;
      endcase
    end
  end

  // Gating with reset suppresses the pulse even when reset arrives during APPLY.
  assign reconfig_req = r_req & ~reset;
  assign mode_out     = r_mode_out;
  assign mode_active  = r_mode_active;
  assign video_reset  = r_video_reset;
  assign busy         = r_busy;
  assign error        = r_error;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer with reduced counter parameters.
module tb_pll_mode_sequencer;

  localparam int unsigned S   = 16;
  localparam int unsigned SET = 64;
  localparam int unsigned LT  = 1000;
  localparam int unsigned MR  = 3;
  localparam int unsigned SS  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mode_in = 8'h00;
  logic       lock = 1'b1;
  logic [7:0] mode_out, mode_active;
  logic       reconfig_req, video_reset, busy, error;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0, dbl_req = 0, err_req = 0;
  logic prev_req = 1'b0;
  int n, base;

  pll_mode_sequencer #(
    .STABLE_CYCLES (S),
    .SETTLE_CYCLES (SET),
    .LOCK_TIMEOUT  (LT),
    .MAX_RETRIES   (MR),
    .SYNC_STAGES   (SS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mode_in          (mode_in),
    .pll_locked_async (lock),
    .mode_out         (mode_out),
    .reconfig_req     (reconfig_req),
    .video_reset      (video_reset),
    .mode_active      (mode_active),
    .busy             (busy),
    .error            (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reconfig_req) req_cnt++;
    if (reconfig_req && prev_req) dbl_req++;
    if (reconfig_req && error) err_req++;
    prev_req = reconfig_req;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // sel: 0 = reconfig_req high, 1 = video_reset low, 2 = error high
  task automatic wait_for(input int sel, input int budget, output int cnt);
    logic hit;
    cnt = 0;
    do begin
      tick();
      cnt++;
      hit = (sel == 0) ? reconfig_req : (sel == 1) ? !video_reset : error;
    end while (!hit && cnt < budget);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mode_out"},    32'(mode_out),     0);
    chk({tag, "_mode_active"}, 32'(mode_active),  0);
    chk({tag, "_req"},         32'(reconfig_req), 0);
    chk({tag, "_vreset"},      32'(video_reset),  1);
    chk({tag, "_busy"},        32'(busy),         1);
    chk({tag, "_error"},       32'(error),        0);
  endtask

  initial begin
    // 1: power-up mode switch to 3
    mode_in = 8'h03; lock = 1'b1; reset = 1'b1;
    ticks(3);
    chk_reset("t0");
    reset = 1'b0;
    wait_for(0, 100, n);
    chk("t1_req_latency", n, S + 3);
    chk("t1_mode_out", 32'(mode_out), 3);
    ticks(10);
    lock = 1'b0;
    chk("t1_req_count", req_cnt, 1);
    chk("t1_vreset_held", 32'(video_reset), 1);
    ticks(500);
    lock = 1'b1;
    wait_for(1, SET + 50, n);
    chk("t1_release", n, SET + SS + 1);
    chk("t1_mode_active", 32'(mode_active), 3);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_req_total", req_cnt, 1);

    // 2: glitchy switch 3->5->3->5
    base = req_cnt;
    mode_in = 8'h05;
    ticks(5);
    chk("t2_vreset", 32'(video_reset), 1);
    chk("t2_busy", 32'(busy), 1);
    mode_in = 8'h03;
    ticks(5);
    mode_in = 8'h05;
    wait_for(0, 100, n);
    chk("t2_req_latency", n, S + 3);
    chk("t2_mode_out", 32'(mode_out), 5);
    ticks(10);
    chk("t2_req_count", req_cnt, base + 1);
    lock = 1'b0;
    ticks(100);
    lock = 1'b1;
    wait_for(1, SET + 50, n);
    chk("t2_release", n, SET + SS + 1);
    chk("t2_mode_active", 32'(mode_active), 5);

    // 4: lock loss in RUN
    base = req_cnt;
    lock = 1'b0;
    ticks(SS);
    chk("t4_vreset_early", 32'(video_reset), 0);
    tick();
    chk("t4_vreset_set", 32'(video_reset), 1);
    ticks(17);
    lock = 1'b1;
    wait_for(1, SET + 50, n);
    chk("t4_release", n, SET + SS + 1);
    chk("t4_no_req", req_cnt, base);

    // 5: lock chatter during SETTLE
    lock = 1'b0;
    ticks(20);
    lock = 1'b1;
    ticks(30);
    chk("t5_vreset_mid", 32'(video_reset), 1);
    lock = 1'b0;
    ticks(5);
    lock = 1'b1;
    wait_for(1, SET + 50, n);
    chk("t5_release", n, SET + SS + 1);
    chk("t5_no_req", req_cnt, base);

    // 3: PLL never relocks
    reset = 1'b1; mode_in = 8'h03; lock = 1'b1;
    ticks(2);
    chk_reset("t3r");
    reset = 1'b0;
    base = req_cnt;
    wait_for(0, 100, n);
    chk("t3_req1_latency", n, S + 3);
    ticks(10);
    lock = 1'b0;
    wait_for(0, LT + 50, n);
    chk("t3_req2_spacing", n, LT + 2 - 10);
    wait_for(0, LT + 50, n);
    chk("t3_req3_spacing", n, LT + 2);
    wait_for(0, LT + 50, n);
    chk("t3_req4_spacing", n, LT + 2);
    chk("t3_mode_out", 32'(mode_out), 3);
    wait_for(2, LT + 50, n);
    chk("t3_error_delay", n, LT + 2);
    chk("t3_error", 32'(error), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_vreset", 32'(video_reset), 1);
    ticks(50);
    chk("t3_req_total", req_cnt, base + 4);
    chk("t3_req_in_error", err_req, 0);

    // 6: reset during APPLY and during WAIT_LOCK
    reset = 1'b1; lock = 1'b1;
    ticks(2);
    chk_reset("t6a");
    reset = 1'b0;
    base = req_cnt;
    wait_for(0, 100, n);
    chk("t6_req_latency", n, S + 3);
    reset = 1'b1;
    #1;
    chk("t6_req_gated", 32'(reconfig_req), 0);
    tick();
    chk_reset("t6b");
    ticks(2);
    chk("t6_no_pulse", req_cnt, base);
    reset = 1'b0;
    wait_for(0, 100, n);
    chk("t6_restart_latency", n, S + 3);
    ticks(10);
    lock = 1'b0;
    ticks(10);
    reset = 1'b1;
    tick();
    chk_reset("t6c");
    chk("t6_double_req", dbl_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
